sr_pq_gen: RTL and testbench

Parametrised shift-register priority queue. It holds up to DEPTH {key,val} entries in a sorted systolic cell array and presents the highest-priority entry at the head every cycle. It adds a selectable min/max ordering, FIFO tie-breaking for equal keys, an occupancy count, combined enqueue-and-dequeue in one cycle, and overflow/underflow error pulses. It sits behind the same enq/deq/kvi/kvo handshake used by the other pq implementations, so existing benches drive it unchanged.

---
 rtl/pq_pkg.sv | 33 +++
 rtl/sr_pq_gen_cell.sv | 66 ++++++
 rtl/sr_pq_gen.sv | 87 ++++++++
 tb/tb_sr_pq_gen.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pq_pkg.sv
// Shared types and helpers for the priority-queue family.
package pq_pkg;

    localparam int unsigned KEY_WIDTH = 8;
    localparam int unsigned VAL_WIDTH = 8;

    typedef struct packed {
        logic [KEY_WIDTH-1:0] key;
        logic [VAL_WIDTH-1:0] val;
    } kv_t;

    typedef struct packed {
        logic valid;
        kv_t  kv;
    } cell_t;

    typedef enum logic [1:0] {
        SEL_HOLD,
        SEL_LOAD,
        SEL_LEFT,
        SEL_RIGHT
    } cell_sel_e;

    // True when key a strictly outranks key b under the chosen ordering.
    function automatic logic pq_higher(
        input logic [KEY_WIDTH-1:0] a,
        input logic [KEY_WIDTH-1:0] b,
        input logic                 min_first
    );
        return min_first ? (a < b) : (a > b);
    endfunction

endpackage

// File: rtl/sr_pq_gen_cell.sv
// One systolic storage cell: picks hold, load-new, take-left or take-right
// from a local compare of the incoming entry against itself and its neighbours.
module sr_pq_gen_cell
    import pq_pkg::*;
#(
    parameter bit MIN_FIRST = 1'b1,
    parameter bit IS_HEAD   = 1'b0
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  enq,
    input  logic  deq,
    input  kv_t   kv_new,
    input  cell_t left,
    input  cell_t right,
    output cell_t state
);

    logic      ahead_self;
    logic      ahead_left;
    logic      ahead_right;
    cell_sel_e sel;

    // "ahead" = valid entry that the new entry does not outrank, so it stays in front.
    always_comb begin
        ahead_self  = state.valid && !pq_higher(kv_new.key, state.kv.key, MIN_FIRST);
        ahead_left  = IS_HEAD || (left.valid && !pq_higher(kv_new.key, left.kv.key, MIN_FIRST));
        ahead_right = right.valid && !pq_higher(kv_new.key, right.kv.key, MIN_FIRST);
    end

    always_comb begin
        sel = SEL_HOLD;
        if (enq && deq) begin
            // Head leaves: the survivors slide up one place while the new entry drops into its slot.
            if (ahead_right)
                sel = SEL_RIGHT;
            else if (IS_HEAD || ahead_self)
                sel = SEL_LOAD;
            else
                sel = SEL_HOLD;
        end else if (enq) begin
            if (ahead_self)
                sel = SEL_HOLD;
            else if (ahead_left)
                sel = SEL_LOAD;
            else
                sel = SEL_LEFT;
        end else if (deq) begin
            sel = SEL_RIGHT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= '0;
        end else begin
            case (sel)
                SEL_LOAD:  state <= '{valid: 1'b1, kv: kv_new};
                SEL_LEFT:  state <= left;
                SEL_RIGHT: state <= right;
                default:   state <= state;
            endcase
        end
    end

endmodule

// File: rtl/sr_pq_gen.sv
// Shift-register priority queue: DEPTH sorted cells, head presented on kvo,
// with occupancy count and registered overflow/underflow pulses.
module sr_pq_gen #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned KEY_WIDTH = pq_pkg::KEY_WIDTH,
    parameter int unsigned VAL_WIDTH = pq_pkg::VAL_WIDTH,
    parameter bit          MIN_FIRST = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [KEY_WIDTH+VAL_WIDTH-1:0] kvi,
    input  logic                           enq,
    input  logic                           deq,
    output logic [KEY_WIDTH+VAL_WIDTH-1:0] kvo,
    output logic                           ovalid,
    output logic                           empty,
    output logic                           full,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           ovf,
    output logic                           udf
);

    import pq_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH + 1);

    cell_t cells [DEPTH];
    kv_t   kv_new;
    logic  enq_eff;
    logic  deq_eff;

    assign kv_new = kvi;

    always_comb begin
        empty   = (count == '0);
        full    = (count == CW'(DEPTH));
        ovalid  = !empty;
        // A full queue still accepts enq when paired with a deq; an empty one drops the deq.
        enq_eff = enq && (!full || deq);
        deq_eff = deq && !empty;
        kvo     = cells[0].valid ? cells[0].kv : '0;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        cell_t left_n;
        cell_t right_n;

        if (i == 0) begin : g_left
            assign left_n = '0;
        end else begin : g_left
            assign left_n = cells[i-1];
        end

        if (i == DEPTH - 1) begin : g_right
            assign right_n = '0;
        end else begin : g_right
            assign right_n = cells[i+1];
        end

        sr_pq_gen_cell #(
            .MIN_FIRST (MIN_FIRST),
            .IS_HEAD   (i == 0)
        ) u_cell (
            .clk    (clk),
            .rst    (rst),
            .enq    (enq_eff),
            .deq    (deq_eff),
            .kv_new (kv_new),
            .left   (left_n),
            .right  (right_n),
            .state  (cells[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            count <= count + CW'(enq_eff) - CW'(deq_eff);
            ovf   <= enq && full && !deq;
            udf   <= deq && empty && !enq;
        end
    end

endmodule

// File: tb/tb_sr_pq_gen.sv
// Self-checking bench: three queue configurations driven in parallel and
// compared against sorted-list models with stable tie ordering.
module tb_sr_pq_gen;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enq = 1'b0;
    logic        deq = 1'b0;
    logic [15:0] kvi = '0;

    logic [15:0] kvo_o    [NI];
    logic        ovalid_o [NI];
    logic        empty_o  [NI];
    logic        full_o   [NI];
    logic        ovf_o    [NI];
    logic        udf_o    [NI];
    logic [3:0]  cnt_a;
    logic [3:0]  cnt_b;
    logic [2:0]  cnt_c;

    logic [15:0] mq [NI][$];
    int          dep [NI] = '{8, 8, 4};
    bit          mf  [NI] = '{1'b1, 1'b0, 1'b1};
    bit          exp_ovf [NI];
    bit          exp_udf [NI];

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sr_pq_gen #(.DEPTH(8), .KEY_WIDTH(8), .VAL_WIDTH(8), .MIN_FIRST(1'b1)) u_min8 (
        .clk(clk), .rst(rst), .kvi(kvi), .enq(enq), .deq(deq),
        .kvo(kvo_o[0]), .ovalid(ovalid_o[0]), .empty(empty_o[0]), .full(full_o[0]),
        .count(cnt_a), .ovf(ovf_o[0]), .udf(udf_o[0]));

    sr_pq_gen #(.DEPTH(8), .KEY_WIDTH(8), .VAL_WIDTH(8), .MIN_FIRST(1'b0)) u_max8 (
        .clk(clk), .rst(rst), .kvi(kvi), .enq(enq), .deq(deq),
        .kvo(kvo_o[1]), .ovalid(ovalid_o[1]), .empty(empty_o[1]), .full(full_o[1]),
        .count(cnt_b), .ovf(ovf_o[1]), .udf(udf_o[1]));

    sr_pq_gen #(.DEPTH(4), .KEY_WIDTH(8), .VAL_WIDTH(8), .MIN_FIRST(1'b1)) u_min4 (
        .clk(clk), .rst(rst), .kvi(kvi), .enq(enq), .deq(deq),
        .kvo(kvo_o[2]), .ovalid(ovalid_o[2]), .empty(empty_o[2]), .full(full_o[2]),
        .count(cnt_c), .ovf(ovf_o[2]), .udf(udf_o[2]));

    function automatic int cnt_of(input int i);
        case (i)
            0:       return int'(cnt_a);
            1:       return int'(cnt_b);
            default: return int'(cnt_c);
        endcase
    endfunction

    function automatic logic [15:0] exp_kvo(input int i);
        return (mq[i].size() > 0) ? mq[i][0] : 16'h0000;
    endfunction

    // New entry goes in front of the first stored entry it strictly outranks.
    task automatic model_insert(input int i, input logic [15:0] kv);
        int          p;
        logic [7:0]  knew;
        logic [7:0]  kold;
        logic [15:0] e;
        p    = mq[i].size();
        knew = kv[15:8];
        for (int j = 0; j < mq[i].size(); j++) begin
            e    = mq[i][j];
            kold = e[15:8];
            if ((mf[i] && knew < kold) || (!mf[i] && knew > kold)) begin
                p = j;
                break;
            end
        end
        mq[i].insert(p, kv);
    endtask

    task automatic step(input logic r, input logic e, input logic d, input logic [15:0] kv);
        rst = r; enq = e; deq = d; kvi = kv;
        @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            exp_ovf[i] = 1'b0;
            exp_udf[i] = 1'b0;
            if (r) begin
                mq[i].delete();
            end else if (e && d && mq[i].size() > 0) begin
                void'(mq[i].pop_front());
                model_insert(i, kv);
            end else if (e) begin
                if (mq[i].size() == dep[i]) exp_ovf[i] = 1'b1;
                else model_insert(i, kv);
            end else if (d) begin
                if (mq[i].size() == 0) exp_udf[i] = 1'b1;
                else void'(mq[i].pop_front());
            end
        end
        #1;
        rst = 1'b0; enq = 1'b0; deq = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < NI; i++) begin
            vectors++; if (kvo_o[i] !== 16'h0) begin miscompares++; $display("FAIL reset_kvo inst%0d got %h want 0000", i, kvo_o[i]); end
            vectors++; if (cnt_of(i) !== 0) begin miscompares++; $display("FAIL reset_count inst%0d got %0d want 0", i, cnt_of(i)); end
            vectors++; if (empty_o[i] !== 1'b1 || full_o[i] !== 1'b0 || ovalid_o[i] !== 1'b0) begin miscompares++; $display("FAIL reset_flags inst%0d got e%b f%b v%b want e1 f0 v0", i, empty_o[i], full_o[i], ovalid_o[i]); end
            vectors++; if (ovf_o[i] !== 1'b0 || udf_o[i] !== 1'b0) begin miscompares++; $display("FAIL reset_err inst%0d got ovf%b udf%b want 0 0", i, ovf_o[i], udf_o[i]); end
        end
    endtask

    task automatic test_fifo_order();
        logic [15:0] ins  [5] = '{16'h080E, 16'h0F0F, 16'h090A, 16'h090B, 16'h090C};
        logic [15:0] emin [5] = '{16'h080E, 16'h090A, 16'h090B, 16'h090C, 16'h0F0F};
        logic [15:0] emax [5] = '{16'h0F0F, 16'h090A, 16'h090B, 16'h090C, 16'h080E};
        step(1'b1, 1'b0, 1'b0, 16'h0);
        foreach (ins[k]) step(1'b0, 1'b1, 1'b0, ins[k]);
        for (int k = 0; k < 5; k++) begin
            vectors++; if (kvo_o[0] !== emin[k]) begin miscompares++; $display("FAIL order_min[%0d] got %h want %h", k, kvo_o[0], emin[k]); end
            vectors++; if (kvo_o[1] !== emax[k]) begin miscompares++; $display("FAIL order_max[%0d] got %h want %h", k, kvo_o[1], emax[k]); end
            step(1'b0, 1'b0, 1'b1, 16'h0);
        end
        vectors++; if (empty_o[0] !== 1'b1 || empty_o[1] !== 1'b1) begin miscompares++; $display("FAIL order_empty got %b%b want 11", empty_o[0], empty_o[1]); end
    endtask

    task automatic test_overflow();
        logic [15:0] ins  [4] = '{16'h0505, 16'h0303, 16'h0707, 16'h0101};
        logic [15:0] outs [4] = '{16'h0200, 16'h0303, 16'h0505, 16'h0707};
        step(1'b1, 1'b0, 1'b0, 16'h0);
        foreach (ins[k]) step(1'b0, 1'b1, 1'b0, ins[k]);
        vectors++; if (full_o[2] !== 1'b1 || cnt_c !== 3'd4) begin miscompares++; $display("FAIL ovf_full got full%b cnt%0d want 1 4", full_o[2], cnt_c); end
        step(1'b0, 1'b1, 1'b0, 16'h0200);
        vectors++; if (ovf_o[2] !== 1'b1) begin miscompares++; $display("FAIL ovf_pulse got %b want 1", ovf_o[2]); end
        vectors++; if (cnt_c !== 3'd4 || kvo_o[2] !== 16'h0101) begin miscompares++; $display("FAIL ovf_hold got cnt%0d kvo %h want 4 0101", cnt_c, kvo_o[2]); end
        step(1'b0, 1'b1, 1'b1, 16'h0200);
        vectors++; if (ovf_o[2] !== 1'b0 || cnt_c !== 3'd4) begin miscompares++; $display("FAIL ovf_swap got ovf%b cnt%0d want 0 4", ovf_o[2], cnt_c); end
        for (int k = 0; k < 4; k++) begin
            vectors++; if (kvo_o[2] !== outs[k]) begin miscompares++; $display("FAIL ovf_drain[%0d] got %h want %h", k, kvo_o[2], outs[k]); end
            step(1'b0, 1'b0, 1'b1, 16'h0);
        end
        vectors++; if (empty_o[2] !== 1'b1) begin miscompares++; $display("FAIL ovf_empty got %b want 1", empty_o[2]); end
    endtask

    task automatic test_underflow();
        step(1'b1, 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 1'b1, 16'h0);
        vectors++; if (udf_o[0] !== 1'b1 || cnt_a !== 4'd0) begin miscompares++; $display("FAIL udf_pulse got udf%b cnt%0d want 1 0", udf_o[0], cnt_a); end
        step(1'b0, 1'b0, 1'b0, 16'h0);
        vectors++; if (udf_o[0] !== 1'b0) begin miscompares++; $display("FAIL udf_clear got %b want 0", udf_o[0]); end
        step(1'b0, 1'b1, 1'b1, 16'h0404);
        vectors++; if (kvo_o[0] !== 16'h0404 || cnt_a !== 4'd1 || udf_o[0] !== 1'b0) begin miscompares++; $display("FAIL udf_enqdeq got kvo %h cnt%0d udf%b want 0404 1 0", kvo_o[0], cnt_a, udf_o[0]); end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 1'b0, 16'h0A01);
        step(1'b0, 1'b1, 1'b0, 16'h0302);
        step(1'b0, 1'b1, 1'b0, 16'h0703);
        step(1'b1, 1'b1, 1'b0, 16'h0104);
        vectors++; if (cnt_a !== 4'd0 || empty_o[0] !== 1'b1 || kvo_o[0] !== 16'h0) begin miscompares++; $display("FAIL rstmid got cnt%0d e%b kvo %h want 0 1 0000", cnt_a, empty_o[0], kvo_o[0]); end
        step(1'b0, 1'b1, 1'b0, 16'h0606);
        vectors++; if (kvo_o[0] !== 16'h0606 || cnt_a !== 4'd1) begin miscompares++; $display("FAIL rstmid_enq got kvo %h cnt%0d want 0606 1", kvo_o[0], cnt_a); end
    endtask

    task automatic test_random();
        int          pe;
        logic        e;
        logic        d;
        logic        r;
        logic [15:0] kv;
        step(1'b1, 1'b0, 1'b0, 16'h0);
        for (int c = 0; c < 10000; c++) begin
            if (c % 500 == 0) pe = 20 + 20 * int'($urandom_range(3));
            e  = ($urandom_range(99) < pe);
            d  = ($urandom_range(99) < (100 - pe));
            r  = ($urandom_range(999) == 0);
            kv = {8'($urandom_range(7)), 8'($urandom_range(255))};
            step(r, e, d, kv);
            for (int i = 0; i < NI; i++) begin
                vectors++; if (kvo_o[i] !== exp_kvo(i)) begin miscompares++; $display("FAIL rand_kvo c%0d inst%0d got %h want %h", c, i, kvo_o[i], exp_kvo(i)); end
                vectors++; if (cnt_of(i) !== mq[i].size()) begin miscompares++; $display("FAIL rand_count c%0d inst%0d got %0d want %0d", c, i, cnt_of(i), mq[i].size()); end
                vectors++; if (ovf_o[i] !== exp_ovf[i] || udf_o[i] !== exp_udf[i]) begin miscompares++; $display("FAIL rand_err c%0d inst%0d got ovf%b udf%b want %b %b", c, i, ovf_o[i], udf_o[i], exp_ovf[i], exp_udf[i]); end
                vectors++; if (empty_o[i] !== (mq[i].size() == 0) || full_o[i] !== (mq[i].size() == dep[i]) || ovalid_o[i] !== (mq[i].size() != 0)) begin miscompares++; $display("FAIL rand_flags c%0d inst%0d got e%b f%b v%b size %0d", c, i, empty_o[i], full_o[i], ovalid_o[i], mq[i].size()); end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_fifo_order();
        test_overflow();
        test_underflow();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
